// File: rtl/icache_if.sv
// ============================================================================
//  icache_if
//  Bus interfaces around the instruction cache:
//    icache_dp_if  : datapath instruction port (datapath = master, cache = slave)
//    icache_mem_if : memory-controller instruction port (cache = master,
//                    memory controller = slave)
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface icache_dp_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport master (
    output imemREN,
    output imemaddr,
    input  ihit,
    input  imemload
  );

  modport slave (
    input  imemREN,
    input  imemaddr,
    output ihit,
    output imemload
  );
endinterface

interface icache_mem_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output iREN,
    output iaddr,
    input  iwait,
    input  iload
  );

  modport slave (
    input  iREN,
    input  iaddr,
    output iwait,
    output iload
  );
endinterface

`default_nettype wire

// File: rtl/icache.sv
// ============================================================================
//  icache
//  Direct-mapped, read-only instruction cache, one 32-bit word per frame.
//  Hits return combinationally; a miss stalls fetch while a single-word fill
//  is performed from the memory controller.
//  Optional feature macro: ICACHE_STATS_EN adds saturating hit/miss counters
//  (ports hit_count / miss_count).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic         CLK,
  input  logic         nRST,
  icache_dp_if.slave   dp,
  icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  // Frame storage; only the valid bits need a reset value.
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];

  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             lookup_hit;

  logic             hit;
  logic [31:0]      load_word;
  logic             ren;
  logic [31:0]      raddr;
  logic             miss_start;
  logic             fill_en;

  // Byte-offset bits of the fetch address carry no information for a word cache.
  logic             addr_lo_unused;
  assign addr_lo_unused = ^dp.imemaddr[1:0];

  assign req_idx  = dp.imemaddr[1+IDX_W:2];
  assign req_tag  = dp.imemaddr[31:2+IDX_W];
  assign fill_idx = miss_addr[1+IDX_W:2];
  assign fill_tag = miss_addr[31:2+IDX_W];

  assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

  // Next-state and output decode; hits are only reported while idle.
  always_comb begin
    next_state = state;
    hit        = 1'b0;
    load_word  = data[req_idx];
    ren        = 1'b0;
    raddr      = 32'h0;
    miss_start = 1'b0;
    fill_en    = 1'b0;
    case (state)
      IDLE: begin
        hit = dp.imemREN && lookup_hit;
        if (dp.imemREN && !lookup_hit) begin
          miss_start = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        ren   = 1'b1;
        raddr = miss_addr;
        if (!mem.iwait) begin
          fill_en    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign dp.ihit     = hit;
  assign dp.imemload = load_word;
  assign mem.iREN    = ren;
  assign mem.iaddr   = raddr;

  // State register and latched miss address; reset abandons any fill in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= 32'h0;
    end else begin
      state <= next_state;
      if (miss_start) begin
        miss_addr <= {dp.imemaddr[31:2], 2'b00};
      end
    end
  end

  // Valid bits: cleared by reset, set when a fill completes.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: a fill overwrites the frame unconditionally.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= mem.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters: hits per cycle, misses per IDLE->FETCH.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_start && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
//  tb_icache
//  Self-checking bench for icache (SETS=16): directed vector table, reset
//  corner sequence, then randomized traffic against a behavioural model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  icache_dp_if  dp_bus ();
  icache_mem_if mem_bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.SETS(16)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .dp   (dp_bus),
    .mem  (mem_bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic check_outs(input string name, input logic e_hit, input logic [31:0] e_data,
                            input logic e_ren, input logic [31:0] e_addr);
    check({name, ".ihit"}, {31'b0, dp_bus.ihit}, {31'b0, e_hit});
    if (e_hit) check({name, ".imemload"}, dp_bus.imemload, e_data);
    check({name, ".iREN"}, {31'b0, mem_bus.iREN}, {31'b0, e_ren});
    check({name, ".iaddr"}, mem_bus.iaddr, e_addr);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic ren, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
    @(negedge clk);
    dp_bus.imemREN  = ren;
    dp_bus.imemaddr = addr;
    mem_bus.iwait   = wt;
    mem_bus.iload   = ld;
    #1;
  endtask

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_data;
    logic        e_ren;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl [21];

  // ---------------- behavioural reference model ----------------
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  logic [31:0] m_data  [16];
  bit          m_fetching;
  logic [31:0] m_fetch_addr;
  int          m_wait_left;
  int          m_hits;
  int          m_misses;
  logic [25:0] tag_pool [4];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
  endfunction

  function automatic int frame_of(input logic [31:0] a);
    return int'((a >> 2) % 32'd16);
  endfunction

  task automatic model_reset();
    for (int f = 0; f < 16; f++) m_valid[f] = 1'b0;
    m_fetching  = 1'b0;
    m_wait_left = 0;
    m_hits      = 0;
    m_misses    = 0;
  endtask

  task automatic rand_cycle();
    logic        ren;
    logic [31:0] addr;
    logic        wt;
    logic [31:0] ld;
    logic        e_hit;
    logic        e_ren;
    logic [31:0] e_addr;
    int          f;
    ren  = ($urandom_range(0, 9) != 0);
    addr = {tag_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    if (m_fetching) begin
      wt = (m_wait_left > 0);
      ld = wt ? $urandom : mem_word(m_fetch_addr);
    end else begin
      wt = 1'($urandom_range(0, 1));
      ld = $urandom;
    end
    drive(ren, addr, wt, ld);
    f = frame_of(addr);
    if (m_fetching) begin
      e_hit  = 1'b0;
      e_ren  = 1'b1;
      e_addr = m_fetch_addr;
    end else begin
      e_hit  = ren && m_valid[f] && (m_word[f] == addr[31:2]);
      e_ren  = 1'b0;
      e_addr = 32'h0;
    end
    check_outs("rand", e_hit, m_data[f], e_ren, e_addr);
    if (m_fetching) begin
      if (!wt) begin
        m_valid[frame_of(m_fetch_addr)] = 1'b1;
        m_word[frame_of(m_fetch_addr)]  = m_fetch_addr[31:2];
        m_data[frame_of(m_fetch_addr)]  = mem_word(m_fetch_addr);
        m_fetching = 1'b0;
      end else begin
        m_wait_left--;
      end
    end else if (ren && !e_hit) begin
      m_fetching   = 1'b1;
      m_fetch_addr = addr & ~32'h3;
      m_wait_left  = $urandom_range(0, 3);
      m_misses++;
    end
    if (e_hit) m_hits++;
    @(posedge clk);
  endtask

  initial begin
    tag_pool[0] = 26'h0;
    tag_pool[1] = 26'h1;
    tag_pool[2] = 26'h2AA_AAAA;
    tag_pool[3] = 26'h3FF_FFFF;

    //           ren   addr          wt    iload          hit   data           iREN  iaddr
    tbl[0]  = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[1]  = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[2]  = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[3]  = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
    tbl[4]  = '{1'b1, 32'h0000_0040, 1'b0, 32'h2002_0005, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[5]  = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h0000_0043, 1'b1, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h0000_0440, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[9]  = '{1'b1, 32'h0000_0440, 1'b0, 32'hAAAA_0440, 1'b0, 32'h0,         1'b1, 32'h440};
    tbl[10] = '{1'b1, 32'h0000_0440, 1'b1, 32'h0,         1'b1, 32'hAAAA_0440, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[12] = '{1'b1, 32'h0000_0040, 1'b0, 32'h2002_0005, 1'b0, 32'h0,         1'b1, 32'h40};
    tbl[13] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0};
    tbl[14] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[15] = '{1'b1, 32'h0000_0084, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h80};
    tbl[16] = '{1'b1, 32'h0000_0084, 1'b0, 32'h8080_8080, 1'b0, 32'h0,         1'b1, 32'h80};
    tbl[17] = '{1'b1, 32'h0000_0084, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
    tbl[18] = '{1'b1, 32'h0000_0084, 1'b0, 32'h8484_8484, 1'b0, 32'h0,         1'b1, 32'h84};
    tbl[19] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0,         1'b1, 32'h8080_8080, 1'b0, 32'h0};
    tbl[20] = '{1'b1, 32'h0000_0084, 1'b1, 32'h0,         1'b1, 32'h8484_8484, 1'b0, 32'h0};

    // ---------------- reset state ----------------
    nrst             = 1'b0;
    dp_bus.imemREN   = 1'b0;
    dp_bus.imemaddr  = 32'h40;
    mem_bus.iwait    = 1'b1;
    mem_bus.iload    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_outs("reset", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("reset.hit_count", hit_count, 32'h0);
    check("reset.miss_count", miss_count, 32'h0);
`endif
    nrst = 1'b1;

    // ---------------- directed vector table ----------------
    for (int v = 0; v < 21; v++) begin
      drive(tbl[v].ren, tbl[v].addr, tbl[v].wt, tbl[v].ld);
      check_outs($sformatf("vec%0d", v), tbl[v].e_hit, tbl[v].e_data, tbl[v].e_ren, tbl[v].e_addr);
      @(posedge clk);
    end

    // ---------------- reset during a fill ----------------
    drive(1'b1, 32'h0000_00C0, 1'b1, 32'h0);
    check_outs("rst_pre", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("table.hit_count", hit_count, 32'd6);
    check("table.miss_count", miss_count, 32'd5);
`endif
    @(posedge clk);
    drive(1'b1, 32'h0000_00C0, 1'b1, 32'h0);
    check_outs("rst_fetch", 1'b0, 32'h0, 1'b1, 32'hC0);
    nrst = 1'b0;
    #1;
    check_outs("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check_outs("rst_after", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    drive(1'b1, 32'h0000_00C0, 1'b0, 32'hC0C0_C0C0);
    check_outs("rst_refill", 1'b0, 32'h0, 1'b1, 32'hC0);
    @(posedge clk);
    drive(1'b1, 32'h0000_00C0, 1'b1, 32'h0);
    check_outs("rst_hit", 1'b1, 32'hC0C0_C0C0, 1'b0, 32'h0);
    @(posedge clk);
    drive(1'b1, 32'h0000_0040, 1'b1, 32'h0);
    check_outs("rst_cleared", 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    drive(1'b1, 32'h0000_0040, 1'b0, 32'h2002_0005);
    check_outs("rst_fill40", 1'b0, 32'h0, 1'b1, 32'h40);
    @(posedge clk);
    drive(1'b0, 32'h0000_0040, 1'b1, 32'h0);
    check_outs("idle", 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef ICACHE_STATS_EN
    check("rst.hit_count", hit_count, 32'd1);
    check("rst.miss_count", miss_count, 32'd2);
`endif
    @(posedge clk);

    // ---------------- randomized traffic vs. model ----------------
    @(negedge clk);
    nrst = 1'b0;
    dp_bus.imemREN = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 800; c++) begin
      rand_cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 32'h0);
`ifdef ICACHE_STATS_EN
    check("rand.hit_count", hit_count, 32'(m_hits));
    check("rand.miss_count", miss_count, 32'(m_misses));
`endif
    check("rand.miss_seen", {31'b0, (m_misses > 10)}, 32'h1);
    check("rand.hit_seen", {31'b0, (m_hits > 10)}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
